// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding, ASCII constants and Morse pattern table
package morse_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_WGAP  = 2'd3;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  typedef struct packed {
    logic [7:0] code;
    logic       hit;
  } lut_t;

  // pat is right-aligned: first symbol sits in bit len-1, dash = 1
  function automatic lut_t morse_lookup(input logic [2:0] len, input logic [6:0] pat);
    lut_t       r;
    logic [6:0] m;
    m      = pat & ~(7'h7F << len);
    r.hit  = 1'b1;
    r.code = ASCII_UNKNOWN;
    case ({len, m})
      {3'd1, 7'b0}:      r.code = "E";
      {3'd1, 7'b1}:      r.code = "T";
      {3'd2, 7'b00}:     r.code = "I";
      {3'd2, 7'b01}:     r.code = "A";
      {3'd2, 7'b10}:     r.code = "N";
      {3'd2, 7'b11}:     r.code = "M";
      {3'd3, 7'b000}:    r.code = "S";
      {3'd3, 7'b001}:    r.code = "U";
      {3'd3, 7'b010}:    r.code = "R";
      {3'd3, 7'b011}:    r.code = "W";
      {3'd3, 7'b100}:    r.code = "D";
      {3'd3, 7'b101}:    r.code = "K";
      {3'd3, 7'b110}:    r.code = "G";
      {3'd3, 7'b111}:    r.code = "O";
      {3'd4, 7'b0000}:   r.code = "H";
      {3'd4, 7'b0001}:   r.code = "V";
      {3'd4, 7'b0010}:   r.code = "F";
      {3'd4, 7'b0100}:   r.code = "L";
      {3'd4, 7'b0110}:   r.code = "P";
      {3'd4, 7'b0111}:   r.code = "J";
      {3'd4, 7'b1000}:   r.code = "B";
      {3'd4, 7'b1001}:   r.code = "X";
      {3'd4, 7'b1010}:   r.code = "C";
      {3'd4, 7'b1011}:   r.code = "Y";
      {3'd4, 7'b1100}:   r.code = "Z";
      {3'd4, 7'b1101}:   r.code = "Q";
      {3'd5, 7'b01111}:  r.code = "1";
      {3'd5, 7'b00111}:  r.code = "2";
      {3'd5, 7'b00011}:  r.code = "3";
      {3'd5, 7'b00001}:  r.code = "4";
      {3'd5, 7'b00000}:  r.code = "5";
      {3'd5, 7'b10000}:  r.code = "6";
      {3'd5, 7'b11000}:  r.code = "7";
      {3'd5, 7'b11100}:  r.code = "8";
      {3'd5, 7'b11110}:  r.code = "9";
      {3'd5, 7'b11111}:  r.code = "0";
      {3'd6, 7'b010101}: r.code = ".";
      {3'd6, 7'b110011}: r.code = ",";
      {3'd6, 7'b001100}: r.code = "?";
      default:           r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational wrapper around morse_lookup
module morse_lut (
  input  logic [2:0] len_i,
  input  logic [6:0] pat_i,
  output logic [7:0] code_o,
  output logic       hit_o
);
  import morse_pkg::*;

  lut_t res;

  assign res    = morse_lookup(len_i, pat_i);
  assign code_o = res.code;
  assign hit_o  = res.hit;

endmodule

// File: rtl/morse_stream_decoder.sv
// rtl/morse_stream_decoder.sv - tick-sampled Morse receiver emitting one ASCII code per character
module morse_stream_decoder #(
  parameter int CNT_W      = 8,
  parameter int DOT_MAX    = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_SYM    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_err,
  output logic       busy
);
  import morse_pkg::*;

  localparam int CNT_TOP = (1 << CNT_W) - 1;

  if (DOT_MAX < 1 || DOT_MAX >= CNT_TOP || LETTER_GAP < 1 || LETTER_GAP >= WORD_GAP ||
      WORD_GAP > CNT_TOP || MAX_SYM < 1 || MAX_SYM > 7) begin : g_bad_params
    $error("morse_stream_decoder: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LG_LIM  = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WG_LIM  = CNT_W'(WORD_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       SYM_LIM = 3'(MAX_SYM);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [MAX_SYM-1:0] pat_q, pat_d, acc_pat;
  logic [2:0]         len_q, len_d, acc_len;
  logic               ovf_q, ovf_d, acc_ovf;
  logic               sym, emit_char, emit_space;
  logic               char_valid_q;
  logic [7:0]         char_code_q;
  logic               char_err_q;
  logic [7:0]         lut_code;
  logic               lut_hit;
  logic [6:0]         lut_pat;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign sym     = (cnt_q > DOT_LIM);

  // Symbol registers as they stand after the current mark is folded in, so an
  // emit on the mark-to-space edge (LETTER_GAP = 1) sees the final symbol.
  always_comb begin
    acc_pat = pat_q;
    acc_len = len_q;
    acc_ovf = ovf_q;
    if (state_q == ST_MARK && !key) begin
      if (len_q < SYM_LIM) begin
        acc_pat = MAX_SYM'({pat_q, sym});
        acc_len = len_q + 3'd1;
      end else begin
        acc_ovf = 1'b1;
      end
    end
  end

  assign lut_pat = 7'(acc_pat);

  morse_lut u_lut (
    .len_i  (acc_len),
    .pat_i  (lut_pat),
    .code_o (lut_code),
    .hit_o  (lut_hit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    emit_char  = 1'b0;
    emit_space = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (key) begin
            state_d = ST_MARK;
            cnt_d   = CNT_ONE;
          end
        end
        ST_MARK: begin
          if (key) begin
            cnt_d = cnt_inc;
          end else begin
            pat_d   = acc_pat;
            len_d   = acc_len;
            ovf_d   = acc_ovf;
            cnt_d   = CNT_ONE;
            state_d = ST_SPACE;
            if (LETTER_GAP == 1) begin
              emit_char = 1'b1;
              pat_d     = '0;
              len_d     = '0;
              ovf_d     = 1'b0;
              state_d   = ST_WGAP;
            end
          end
        end
        ST_SPACE: begin
          if (key) begin
            state_d = ST_MARK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LG_LIM) begin
              emit_char = 1'b1;
              pat_d     = '0;
              len_d     = '0;
              ovf_d     = 1'b0;
              state_d   = ST_WGAP;
            end
          end
        end
        default: begin
          if (key) begin
            state_d = ST_MARK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == WG_LIM) begin
              emit_space = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= 8'h00;
      char_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      char_valid_q <= emit_char | emit_space;
      if (emit_space) begin
        char_code_q <= ASCII_SPACE;
        char_err_q  <= 1'b0;
      end else if (emit_char) begin
        if (acc_ovf || !lut_hit) begin
          char_code_q <= ASCII_UNKNOWN;
          char_err_q  <= 1'b1;
        end else begin
          char_code_q <= lut_code;
          char_err_q  <= 1'b0;
        end
      end
    end
  end

  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_err   = char_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb/tb_morse_stream_decoder.sv - scoreboard bench for morse_stream_decoder
module tb_morse_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_err;
  logic       busy;

  typedef struct {
    logic [7:0] code;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_v  = 1'b0;

  string      vp[10] = '{"--.-", "-...", "-.--", "--..", ".----", ".....", "----.",
                         ".-.-.-", "--..--", "..--.."};
  logic [7:0] vc[10] = '{8'h51, 8'h42, 8'h59, 8'h5A, 8'h31, 8'h35, 8'h39, 8'h2E, 8'h2C, 8'h3F};

  morse_stream_decoder #(
    .CNT_W(8), .DOT_MAX(3), .LETTER_GAP(3), .WORD_GAP(7), .MAX_SYM(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key        (key),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (char_valid) begin
      check("back_to_back", 32'(prev_v), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("char_code", 32'(char_code), 32'(e.code));
        check("char_err", 32'(char_err), 32'(e.err));
        check("emit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_v <= char_valid;
  end

  // One tick-qualified sample; optionally records the emission it should cause.
  task automatic tk(input logic k, input logic push, input logic [7:0] code, input logic err);
    exp_t e;
    @(negedge clk);
    tick = 1'b1;
    key  = k;
    if (push) begin
      e.code = code;
      e.err  = err;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic send_char(input string p, input int dot_t, input int dash_t,
                           input logic [7:0] code, input logic err);
    for (int i = 0; i < p.len(); i++) begin
      int n;
      n = (p[i] == 8'h2D) ? dash_t : dot_t;
      repeat (n) tk(1'b1, 1'b0, 8'h00, 1'b0);
      if (i != p.len() - 1) tk(1'b0, 1'b0, 8'h00, 1'b0);
    end
    tk(1'b0, 1'b0, 8'h00, 1'b0);
    tk(1'b0, 1'b0, 8'h00, 1'b0);
    tk(1'b0, 1'b1, code, err);
  endtask

  task automatic word_gap();
    repeat (3) tk(1'b0, 1'b0, 8'h00, 1'b0);
    tk(1'b0, 1'b1, 8'h20, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    key  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_code", 32'(char_code), 32'h00);
    check("rst_err", 32'(char_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    send_char(".", 1, 4, 8'h45, 1'b0);
    word_gap();
    @(negedge clk);
    check("busy_after_e", 32'(busy), 32'd0);

    send_char(".-", 2, 6, 8'h41, 1'b0);
    send_char("-", 1, 5, 8'h54, 1'b0);
    word_gap();
    @(negedge clk);
    check("busy_after_t", 32'(busy), 32'd0);

    send_char("......", 1, 4, 8'h3F, 1'b1);
    send_char(".......", 1, 4, 8'h3F, 1'b1);
    send_char("-----", 1, 4, 8'h30, 1'b0);
    word_gap();

    for (int i = 0; i < 10; i++) send_char(vp[i], 1, 4, vc[i], 1'b0);
    send_char("..--", 1, 4, 8'h3F, 1'b1);
    word_gap();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key = i[0];
    end
    key = 1'b0;
    @(negedge clk);
    check("gated_busy", 32'(busy), 32'd0);
    check("gated_code_hold", 32'(char_code), 32'h20);

    repeat (3) tk(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b1;
    key  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    key  = 1'b0;
    check("midrst_valid", 32'(char_valid), 32'd0);
    check("midrst_code", 32'(char_code), 32'h00);
    check("midrst_err", 32'(char_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    send_char("...", 1, 4, 8'h53, 1'b0);
    word_gap();

    repeat (300) tk(1'b1, 1'b0, 8'h00, 1'b0);
    check("sat_cnt", 32'(dut.cnt_q), 32'd255);
    check("sat_busy", 32'(busy), 32'd1);
    tk(1'b0, 1'b0, 8'h00, 1'b0);
    tk(1'b0, 1'b0, 8'h00, 1'b0);
    tk(1'b0, 1'b1, 8'h54, 1'b0);
    word_gap();

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
